// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - coin change-return controller with ejector handshake, jam timeout and inventory
//
// Plans and dispenses the change selected by a 3-bit code from the vending FSM.
// Dimes are replaced by pairs of nickels when dime inventory runs short.
// Coins are ejected one at a time, and each coin waits for its chute sensor pulse.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req_valid, change_code  change request (000 none, 001 N, 010 D, 011 N+D, 100 D+D)
//   ready                   high only while idle; a request is taken when req_valid && ready
//   done, short, bad_code   one-cycle status pulses
//   eject_n, eject_d        ejector solenoid drives; at most one is high at a time
//   sense_n, sense_d        chute sensor pulses, one per coin that passes
//   jam                     sticky fault after an ejector timeout; cleared only by reset
//   refill_n, refill_d      hopper refill pulses, one coin per pulse
//   nickel_count, dime_count  current coin inventory
module change_dispenser #(
    parameter int CNT_W        = 8,
    parameter int INIT_NICKELS = 20,
    parameter int INIT_DIMES   = 20,
    parameter int TIMEOUT      = 200,
    parameter int TO_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [2:0]       change_code,
    output logic             ready,
    output logic             done,
    output logic             short,
    output logic             bad_code,
    output logic             eject_n,
    output logic             eject_d,
    input  logic             sense_n,
    input  logic             sense_d,
    output logic             jam,
    input  logic             refill_n,
    input  logic             refill_d,
    output logic [CNT_W-1:0] nickel_count,
    output logic [CNT_W-1:0] dime_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAN,
        S_WAIT_D,
        S_WAIT_N,
        S_GAP,
        S_DONE,
        S_JAM
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic [1:0]       dplan_q, dplan_d;
    // The nickel plan needs three bits: two missing dimes become four nickels.
    logic [2:0]       nplan_q, nplan_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [CNT_W-1:0] ncnt_q, ncnt_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             short_q, short_d;
    logic             bad_q, bad_d;

    // Plan arithmetic, evaluated from the latched code while in PLAN.
    logic [1:0]       dimes_req;
    logic             nickels_req;
    logic [1:0]       dimes_plan;
    logic [1:0]       dimes_missing;
    logic [2:0]       nickels_plan;
    logic             plan_short;

    // A coin is taken from inventory only when its own sensor fires while its ejector is driven.
    logic             n_taken;
    logic             d_taken;

    always_comb begin
        dimes_req   = 2'd0;
        nickels_req = 1'b0;
        case (code_q)
            3'b001:  nickels_req = 1'b1;
            3'b010:  dimes_req   = 2'd1;
            3'b011: begin
                nickels_req = 1'b1;
                dimes_req   = 2'd1;
            end
            3'b100:  dimes_req   = 2'd2;
            default: begin
                dimes_req   = 2'd0;
                nickels_req = 1'b0;
            end
        endcase

        if (dcnt_q < {{(CNT_W-2){1'b0}}, dimes_req}) begin
            dimes_plan = dcnt_q[1:0];
        end else begin
            dimes_plan = dimes_req;
        end
        dimes_missing = dimes_req - dimes_plan;
        nickels_plan  = {2'b00, nickels_req} + {dimes_missing, 1'b0};
        plan_short    = {{(CNT_W-3){1'b0}}, nickels_plan} > ncnt_q;
    end

    assign n_taken = (state_q == S_WAIT_N) && sense_n;
    assign d_taken = (state_q == S_WAIT_D) && sense_d;

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            code_q  <= 3'b000;
            dplan_q <= 2'd0;
            nplan_q <= 3'd0;
            to_q    <= '0;
            ncnt_q  <= CNT_W'(INIT_NICKELS);
            dcnt_q  <= CNT_W'(INIT_DIMES);
            short_q <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            dplan_q <= dplan_d;
            nplan_q <= nplan_d;
            to_q    <= to_d;
            ncnt_q  <= ncnt_d;
            dcnt_q  <= dcnt_d;
            short_q <= short_d;
            bad_q   <= bad_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dplan_d = dplan_q;
        nplan_d = nplan_q;
        short_d = 1'b0;
        bad_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (change_code == 3'b000) begin
                        state_d = S_DONE;
                    end else if (change_code <= 3'b100) begin
                        code_d  = change_code;
                        state_d = S_PLAN;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            S_PLAN: begin
                if (plan_short) begin
                    short_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    dplan_d = dimes_plan;
                    nplan_d = nickels_plan;
                    state_d = (dimes_plan != 2'd0) ? S_WAIT_D : S_WAIT_N;
                end
            end
            S_WAIT_D: begin
                if (sense_d) begin
                    dplan_d = dplan_q - 2'd1;
                    state_d = S_GAP;
                end else if (to_q == TO_LAST) begin
                    state_d = S_JAM;
                end
            end
            S_WAIT_N: begin
                if (sense_n) begin
                    nplan_d = nplan_q - 3'd1;
                    state_d = S_GAP;
                end else if (to_q == TO_LAST) begin
                    state_d = S_JAM;
                end
            end
            S_GAP: begin
                // Dimes always go first so a mixed request ends on nickels.
                if (dplan_q != 2'd0) begin
                    state_d = S_WAIT_D;
                end else if (nplan_q != 3'd0) begin
                    state_d = S_WAIT_N;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_JAM: begin
                state_d = S_JAM;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The timeout counts only while an ejector stays in the same wait state.
        // Every entry into a wait state, including from GAP, starts again from zero.
        if ((state_q == S_WAIT_D || state_q == S_WAIT_N) && state_d == state_q) begin
            to_d = to_q + TO_ONE;
        end else begin
            to_d = '0;
        end

        // Refill and a sensed coin of the same type in one cycle cancel out.
        ncnt_d = ncnt_q;
        if (refill_n && !n_taken) begin
            if (ncnt_q != CNT_MAX) begin
                ncnt_d = ncnt_q + CNT_ONE;
            end
        end else if (!refill_n && n_taken) begin
            ncnt_d = ncnt_q - CNT_ONE;
        end

        dcnt_d = dcnt_q;
        if (refill_d && !d_taken) begin
            if (dcnt_q != CNT_MAX) begin
                dcnt_d = dcnt_q + CNT_ONE;
            end
        end else if (!refill_d && d_taken) begin
            dcnt_d = dcnt_q - CNT_ONE;
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        ready    = 1'b0;
        done     = 1'b0;
        eject_n  = 1'b0;
        eject_d  = 1'b0;
        jam      = 1'b0;
        case (state_q)
            S_IDLE:   ready   = 1'b1;
            S_WAIT_D: eject_d = 1'b1;
            S_WAIT_N: eject_n = 1'b1;
            S_DONE:   done    = 1'b1;
            S_JAM:    jam     = 1'b1;
            default:  ready   = 1'b0;
        endcase
        short        = short_q;
        bad_code     = bad_q;
        nickel_count = ncnt_q;
        dime_count   = dcnt_q;
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] change_code = 3'b000;
    logic       ready, done, short, bad_code, eject_n, eject_d, jam;
    logic       sense_n = 1'b0;
    logic       sense_d = 1'b0;
    logic       refill_n = 1'b0;
    logic       refill_d = 1'b0;
    logic [7:0] nickel_count, dime_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    change_dispenser dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .change_code(change_code),
        .ready(ready), .done(done), .short(short), .bad_code(bad_code),
        .eject_n(eject_n), .eject_d(eject_d), .sense_n(sense_n), .sense_d(sense_d),
        .jam(jam), .refill_n(refill_n), .refill_d(refill_d),
        .nickel_count(nickel_count), .dime_count(dime_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 1'b0; change_code = 3'b000;
        sense_n = 1'b0; sense_d = 1'b0; refill_n = 1'b0; refill_d = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Presents one request in cycle 0 and answers each ejector rise with its sensor
    // pulse three cycles later. Cycle numbers returned are relative to the accept cycle.
    task automatic run_dispense(input logic [2:0] code, input int budget,
                                output int d_rises, output int n_rises, output int hi_cycles,
                                output int both_high, output int order_bad, output int gap_len,
                                output int dones, output int done_cyc, output int ready_cyc);
        int  cd_d, cd_n, fall_cyc;
        logic pd, pn;
        d_rises = 0; n_rises = 0; hi_cycles = 0; both_high = 0; order_bad = 0;
        gap_len = -1; dones = 0; done_cyc = -1; ready_cyc = -1;
        cd_d = 0; cd_n = 0; fall_cyc = -1; pd = 1'b0; pn = 1'b0;
        req_valid = 1'b1; change_code = code;
        tick();
        req_valid = 1'b0; change_code = 3'b000;
        for (int cyc = 1; cyc < budget; cyc++) begin
            sense_d = 1'b0; sense_n = 1'b0;
            if ((eject_d && !pd) || (eject_n && !pn)) begin
                if (fall_cyc >= 0 && (cyc - fall_cyc) > gap_len) gap_len = cyc - fall_cyc;
            end
            if ((!eject_d && pd) || (!eject_n && pn)) fall_cyc = cyc;
            if (eject_d && !pd) begin
                d_rises++; cd_d = 3;
                if (n_rises > 0) order_bad++;
            end else if (eject_d) begin
                cd_d--;
                if (cd_d == 0) sense_d = 1'b1;
            end
            if (eject_n && !pn) begin
                n_rises++; cd_n = 3;
            end else if (eject_n) begin
                cd_n--;
                if (cd_n == 0) sense_n = 1'b1;
            end
            if (eject_d || eject_n) hi_cycles++;
            if (eject_d && eject_n) both_high++;
            if (done) begin dones++; done_cyc = cyc; end
            if (ready && dones > 0) begin
                ready_cyc = cyc;
                break;
            end
            pd = eject_d; pn = eject_n;
            tick();
        end
        sense_d = 1'b0; sense_n = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", ready); end
        checks++; if ({done, short, bad_code} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {done, short, bad_code}); end
        checks++; if ({eject_d, eject_n, jam} !== 3'b000) begin errors++; $display("FAIL reset_eject_jam got %b want 000", {eject_d, eject_n, jam}); end
        checks++; if (nickel_count !== 8'd20 || dime_count !== 8'd20) begin errors++; $display("FAIL reset_counts got %0d/%0d want 20/20", nickel_count, dime_count); end
    endtask

    task automatic test_nickel_dime();
        int dr, nr, hi, both, ob, gap, dn, dc, rc;
        do_reset();
        run_dispense(3'b011, 60, dr, nr, hi, both, ob, gap, dn, dc, rc);
        checks++; if (dr !== 1 || nr !== 1) begin errors++; $display("FAIL nd_rises got d%0d n%0d want d1 n1", dr, nr); end
        checks++; if (ob !== 0 || both !== 0) begin errors++; $display("FAIL nd_order got order_bad %0d both %0d want 0 0", ob, both); end
        checks++; if (gap !== 1) begin errors++; $display("FAIL nd_gap got %0d want 1", gap); end
        checks++; if (hi !== 8) begin errors++; $display("FAIL nd_eject_cycles got %0d want 8", hi); end
        checks++; if (dn !== 1 || dc !== 12) begin errors++; $display("FAIL nd_done got %0d pulses at %0d want 1 at 12", dn, dc); end
        checks++; if (rc !== 13) begin errors++; $display("FAIL nd_ready got %0d want 13", rc); end
        checks++; if (nickel_count !== 8'd19 || dime_count !== 8'd19) begin errors++; $display("FAIL nd_counts got %0d/%0d want 19/19", nickel_count, dime_count); end
    endtask

    task automatic test_dime_substitution();
        int dr, nr, hi, both, ob, gap, dn, dc, rc;
        do_reset();
        for (int i = 0; i < 9; i++) run_dispense(3'b100, 60, dr, nr, hi, both, ob, gap, dn, dc, rc);
        run_dispense(3'b010, 60, dr, nr, hi, both, ob, gap, dn, dc, rc);
        checks++; if (dime_count !== 8'd1 || nickel_count !== 8'd20) begin errors++; $display("FAIL sub_drain got %0d/%0d want n20/d1", nickel_count, dime_count); end
        run_dispense(3'b100, 60, dr, nr, hi, both, ob, gap, dn, dc, rc);
        checks++; if (dr !== 1 || nr !== 2) begin errors++; $display("FAIL sub_rises got d%0d n%0d want d1 n2", dr, nr); end
        checks++; if (ob !== 0 || both !== 0) begin errors++; $display("FAIL sub_order got order_bad %0d both %0d want 0 0", ob, both); end
        checks++; if (dn !== 1 || dc !== 17) begin errors++; $display("FAIL sub_done got %0d pulses at %0d want 1 at 17", dn, dc); end
        checks++; if (dime_count !== 8'd0 || nickel_count !== 8'd18) begin errors++; $display("FAIL sub_counts got n%0d d%0d want n18 d0", nickel_count, dime_count); end
    endtask

    // Continues from test_dime_substitution: no dimes, 18 nickels.
    task automatic test_short();
        int dr, nr, hi, both, ob, gap, dn, dc, rc;
        int ej;
        for (int i = 0; i < 4; i++) run_dispense(3'b100, 60, dr, nr, hi, both, ob, gap, dn, dc, rc);
        checks++; if (nickel_count !== 8'd2 || nr !== 4) begin errors++; $display("FAIL short_drain got n%0d rises %0d want n2 rises 4", nickel_count, nr); end
        refill_n = 1'b1; tick(); refill_n = 1'b0;
        checks++; if (nickel_count !== 8'd3) begin errors++; $display("FAIL short_refill got %0d want 3", nickel_count); end
        ej = 0;
        req_valid = 1'b1; change_code = 3'b100;
        tick();
        req_valid = 1'b0; change_code = 3'b000;
        ej += int'(eject_d) + int'(eject_n);
        checks++; if (ready !== 1'b0 || short !== 1'b0) begin errors++; $display("FAIL short_plan got ready %0b short %0b want 0 0", ready, short); end
        tick();
        ej += int'(eject_d) + int'(eject_n);
        checks++; if (short !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL short_pulse got short %0b ready %0b want 1 1", short, ready); end
        tick();
        ej += int'(eject_d) + int'(eject_n);
        checks++; if (short !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL short_once got short %0b done %0b want 0 0", short, done); end
        checks++; if (ej !== 0) begin errors++; $display("FAIL short_no_eject got %0d want 0", ej); end
        checks++; if (nickel_count !== 8'd3 || dime_count !== 8'd0) begin errors++; $display("FAIL short_counts got n%0d d%0d want n3 d0", nickel_count, dime_count); end
    endtask

    task automatic test_jam();
        int hi, jc;
        do_reset();
        hi = 0; jc = -1;
        req_valid = 1'b1; change_code = 3'b001;
        tick();
        req_valid = 1'b0; change_code = 3'b000;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (eject_n) hi++;
            if (jam) begin jc = cyc; break; end
            tick();
        end
        checks++; if (hi !== 200) begin errors++; $display("FAIL jam_eject_cycles got %0d want 200", hi); end
        checks++; if (jc !== 202) begin errors++; $display("FAIL jam_cycle got %0d want 202", jc); end
        checks++; if (ready !== 1'b0 || eject_n !== 1'b0 || eject_d !== 1'b0) begin errors++; $display("FAIL jam_outputs got ready %0b ej %b want 0 00", ready, {eject_d, eject_n}); end
        refill_n = 1'b1; tick(); refill_n = 1'b0;
        checks++; if (nickel_count !== 8'd21) begin errors++; $display("FAIL jam_refill got %0d want 21", nickel_count); end
        sense_n = 1'b1; tick(); sense_n = 1'b0;
        tick(); tick();
        checks++; if (nickel_count !== 8'd21 || jam !== 1'b1) begin errors++; $display("FAIL jam_sticky got n%0d jam %0b want n21 jam 1", nickel_count, jam); end
        do_reset();
        checks++; if (jam !== 1'b0 || ready !== 1'b1 || {done, short, bad_code, eject_d, eject_n} !== 5'b0) begin errors++; $display("FAIL jam_reset got jam %0b ready %0b", jam, ready); end
        checks++; if (nickel_count !== 8'd20 || dime_count !== 8'd20) begin errors++; $display("FAIL jam_reset_counts got %0d/%0d want 20/20", nickel_count, dime_count); end
    endtask

    task automatic test_codes();
        do_reset();
        req_valid = 1'b1; change_code = 3'b110;
        tick();
        req_valid = 1'b0; change_code = 3'b000;
        checks++; if (bad_code !== 1'b1 || ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL bad_pulse got bad %0b ready %0b done %0b want 1 1 0", bad_code, ready, done); end
        tick();
        checks++; if (bad_code !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL bad_once got bad %0b ready %0b want 0 1", bad_code, ready); end
        req_valid = 1'b1; change_code = 3'b000;
        tick();
        req_valid = 1'b0;
        checks++; if (done !== 1'b1 || ready !== 1'b0 || eject_d !== 1'b0 || eject_n !== 1'b0) begin errors++; $display("FAIL zero_done got done %0b ready %0b ej %b want 1 0 00", done, ready, {eject_d, eject_n}); end
        tick();
        checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL zero_idle got done %0b ready %0b want 0 1", done, ready); end
        checks++; if (nickel_count !== 8'd20 || dime_count !== 8'd20) begin errors++; $display("FAIL zero_counts got %0d/%0d want 20/20", nickel_count, dime_count); end
    endtask

    task automatic test_refill();
        do_reset();
        refill_n = 1'b1;
        repeat (240) tick();
        refill_n = 1'b0;
        checks++; if (nickel_count !== 8'd255) begin errors++; $display("FAIL refill_sat got %0d want 255", nickel_count); end
        refill_d = 1'b1;
        repeat (3) tick();
        refill_d = 1'b0;
        checks++; if (dime_count !== 8'd23) begin errors++; $display("FAIL refill_dime got %0d want 23", dime_count); end
        do_reset();
        req_valid = 1'b1; change_code = 3'b001;
        tick();
        req_valid = 1'b0; change_code = 3'b000;
        tick();
        checks++; if (eject_n !== 1'b1 || eject_d !== 1'b0) begin errors++; $display("FAIL coincide_eject got %b want 01", {eject_d, eject_n}); end
        sense_n = 1'b1; refill_n = 1'b1;
        tick();
        sense_n = 1'b0; refill_n = 1'b0;
        checks++; if (nickel_count !== 8'd20 || eject_n !== 1'b0) begin errors++; $display("FAIL coincide_count got %0d ej_n %0b want 20 0", nickel_count, eject_n); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL coincide_done got %0b want 1", done); end
    endtask

    task automatic test_reset_mid_dispense();
        do_reset();
        req_valid = 1'b1; change_code = 3'b010;
        tick();
        req_valid = 1'b0; change_code = 3'b000;
        tick();
        tick();
        checks++; if (eject_d !== 1'b1) begin errors++; $display("FAIL midreset_before got %0b want 1", eject_d); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (eject_d !== 1'b0 || ready !== 1'b1 || dime_count !== 8'd20) begin errors++; $display("FAIL midreset_after got ej_d %0b ready %0b d%0d want 0 1 20", eject_d, ready, dime_count); end
    endtask

    initial begin
        test_reset();
        test_nickel_dime();
        test_dime_substitution();
        test_short();
        test_jam();
        test_codes();
        test_refill();
        test_reset_mid_dispense();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
